// File: rtl/seq_calculator.sv
// seq_calculator: multi-cycle unsigned calculator (add, sub, mul, div, mod).
// add/sub and the error cases finish in one cycle. mul uses a shift-add loop
// and div/mod use restoring division, each producing one bit per cycle.
// Handshake: start is sampled in IDLE, busy is high outside IDLE, and done
// pulses for one cycle with the result and flags valid.
module seq_calculator #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    input  logic [4:0]         op_select,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               negative,
    output logic               div_by_zero,
    output logic               invalid_op
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [4:0] OP_ADD = 5'b01000;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00001;
    localparam logic [4:0] OP_MOD = 5'b10000;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     count;
    logic              is_mod;
    logic [RW-1:0]     mul_acc, mul_mcand;
    logic [WIDTH-1:0]  mul_mplier;
    logic [WIDTH-1:0]  div_rem, div_quo, div_divisor;

    logic              b_zero;
    logic              last_iter;
    logic [RW-1:0]     mul_acc_next;
    logic [WIDTH:0]    div_shift, div_trial;
    logic              div_fits;
    logic [WIDTH-1:0]  div_rem_next, div_quo_next;

    // Iteration datapath: one shift-add step and one restoring-division step.
    always_comb begin
        b_zero       = (operand_b == '0);
        last_iter    = (count == '0);
        mul_acc_next = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
        div_shift    = {div_rem, div_quo[WIDTH-1]};
        div_trial    = div_shift - {1'b0, div_divisor};
        div_fits     = ~div_trial[WIDTH];
        div_rem_next = div_fits ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_next = {div_quo[WIDTH-2:0], div_fits};
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        // NOTE: defaults come first so no path leaves an output unassigned (which would infer a latch).
        state_next = state;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op_select)
                        OP_MUL:         state_next = S_MUL;
                        OP_DIV, OP_MOD: state_next = b_zero ? S_DONE : S_DIV;
                        default:        state_next = S_DONE;
                    endcase
                end
            end
            S_MUL, S_DIV: if (last_iter) state_next = S_DONE;
            default:      state_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration registers, result and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            is_mod      <= 1'b0;
            mul_acc     <= '0;
            mul_mcand   <= '0;
            mul_mplier  <= '0;
            div_rem     <= '0;
            div_quo     <= '0;
            div_divisor <= '0;
            result      <= '0;
            negative    <= 1'b0;
            div_by_zero <= 1'b0;
            invalid_op  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count       <= CW'(WIDTH - 1);
                        is_mod      <= (op_select == OP_MOD);
                        mul_acc     <= '0;
                        mul_mcand   <= RW'(operand_a);
                        mul_mplier  <= operand_b;
                        div_rem     <= '0;
                        div_quo     <= operand_a;
                        div_divisor <= operand_b;
                        result      <= '0;
                        negative    <= 1'b0;
                        div_by_zero <= 1'b0;
                        invalid_op  <= 1'b0;
                        case (op_select)
                            OP_ADD: result <= RW'(operand_a) + RW'(operand_b);
                            OP_SUB: begin
                                result   <= RW'(operand_a) - RW'(operand_b);
                                negative <= (operand_a < operand_b);
                            end
                            OP_MUL: ;
                            OP_DIV, OP_MOD: begin
                                if (b_zero) begin
                                    result      <= '1;
                                    div_by_zero <= 1'b1;
                                end
                            end
                            default: invalid_op <= 1'b1;
                        endcase
                    end
                end
                S_MUL: begin
                    mul_acc    <= mul_acc_next;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    count      <= count - 1'b1;
                    if (last_iter) result <= mul_acc_next;
                end
                S_DIV: begin
                    div_rem <= div_rem_next;
                    div_quo <= div_quo_next;
                    count   <= count - 1'b1;
                    if (last_iter) result <= is_mod ? RW'(div_rem_next) : RW'(div_quo_next);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_calculator.sv
// Testbench for seq_calculator (WIDTH=8): directed vector table, hand-written
// corner sequences (mid-op start, reset abort) and randomized operations
// compared against an arithmetic reference model.
module tb_seq_calculator;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  operand_a, operand_b;
    logic [4:0]    op_select;
    logic          busy, done, negative, div_by_zero, invalid_op;
    logic [2*W-1:0] result;

    int checks = 0;
    int errors = 0;

    seq_calculator #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .operand_a(operand_a), .operand_b(operand_b), .op_select(op_select),
        .busy(busy), .done(done), .result(result),
        .negative(negative), .div_by_zero(div_by_zero), .invalid_op(invalid_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [4:0]     op;
        logic [2*W-1:0] res;
        logic           neg;
        logic           dbz;
        logic           inv;
        int             lat;
    } vec_t;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: the arithmetic rules with plain integers.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] op);
        vec_t v;
        int ai = int'(a);
        int bi = int'(b);
        v.a = a; v.b = b; v.op = op;
        v.res = '0; v.neg = 1'b0; v.dbz = 1'b0; v.inv = 1'b0; v.lat = 1;
        case (op)
            5'b01000: v.res = 16'(ai + bi);
            5'b00100: begin v.res = 16'(ai - bi); v.neg = (ai < bi); end
            5'b00010: begin v.res = 16'(ai * bi); v.lat = W + 1; end
            5'b00001, 5'b10000: begin
                if (bi == 0) begin
                    v.res = 16'hFFFF; v.dbz = 1'b1;
                end else begin
                    v.res = (op == 5'b00001) ? 16'(ai / bi) : 16'(ai % bi);
                    v.lat = W + 1;
                end
            end
            default: v.inv = 1'b1;
        endcase
        return v;
    endfunction

    // Issue one op starting now (#1 after an edge, DUT idle); report outputs at
    // done and the latency in cycles. poke_at>0 pulses a stray start mid-op.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] op,
                          input int poke_at, output vec_t got);
        int lat;
        operand_a = a; operand_b = b; op_select = op; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        operand_a = W'($urandom); operand_b = W'($urandom); op_select = 5'($urandom);
        lat = 1;
        while (!done && lat < 40) begin
            if (lat == poke_at) begin
                start = 1'b1; op_select = 5'b01000;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        got.a = a; got.b = b; got.op = op;
        got.res = result; got.neg = negative; got.dbz = div_by_zero; got.inv = invalid_op;
        got.lat = lat;
        @(posedge clk); #1;
        check("done_pulse_end", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    task automatic compare(input string tag, input vec_t got, input vec_t exp);
        check({tag, "_result"}, got.res, exp.res);
        check({tag, "_negative"}, got.neg, exp.neg);
        check({tag, "_div_by_zero"}, got.dbz, exp.dbz);
        check({tag, "_invalid_op"}, got.inv, exp.inv);
        check({tag, "_latency"}, got.lat, exp.lat);
    endtask

    vec_t vecs[15];
    vec_t got, exp_v;
    logic [4:0] ops[5];

    initial begin
        vecs[0]  = '{8'd200, 8'd100, 5'b01000, 16'h012C, 0, 0, 0, 1};
        vecs[1]  = '{8'd5,   8'd7,   5'b00100, 16'hFFFE, 1, 0, 0, 1};
        vecs[2]  = '{8'd7,   8'd5,   5'b00100, 16'h0002, 0, 0, 0, 1};
        vecs[3]  = '{8'd255, 8'd255, 5'b00010, 16'hFE01, 0, 0, 0, 9};
        vecs[4]  = '{8'd200, 8'd7,   5'b00001, 16'h001C, 0, 0, 0, 9};
        vecs[5]  = '{8'd200, 8'd7,   5'b10000, 16'h0004, 0, 0, 0, 9};
        vecs[6]  = '{8'd9,   8'd0,   5'b00001, 16'hFFFF, 0, 1, 0, 1};
        vecs[7]  = '{8'd9,   8'd0,   5'b10000, 16'hFFFF, 0, 1, 0, 1};
        vecs[8]  = '{8'd3,   8'd4,   5'b00110, 16'h0000, 0, 0, 1, 1};
        vecs[9]  = '{8'd3,   8'd4,   5'b00000, 16'h0000, 0, 0, 1, 1};
        vecs[10] = '{8'd255, 8'd255, 5'b01000, 16'h01FE, 0, 0, 0, 1};
        vecs[11] = '{8'd0,   8'd37,  5'b00010, 16'h0000, 0, 0, 0, 9};
        vecs[12] = '{8'd5,   8'd200, 5'b00001, 16'h0000, 0, 0, 0, 9};
        vecs[13] = '{8'd5,   8'd200, 5'b10000, 16'h0005, 0, 0, 0, 9};
        vecs[14] = '{8'd255, 8'd1,   5'b00001, 16'h00FF, 0, 0, 0, 9};
        ops = '{5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};

        reset = 1'b1; start = 1'b0;
        operand_a = '0; operand_b = '0; op_select = '0;
        #12;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_flags", {negative, div_by_zero, invalid_op}, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, 0, got);
            compare($sformatf("vec%0d", i), got, vecs[i]);
        end

        // Stray start three cycles into a multiply must be ignored.
        run_op(8'd255, 8'd255, 5'b00010, 3, got);
        compare("mul_poke", got, vecs[3]);

        // Reset four cycles into mul 13*11 aborts immediately.
        operand_a = 8'd13; operand_b = 8'd11; op_select = 5'b00010; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("pre_reset_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_done", done, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        run_op(8'd13, 8'd11, 5'b00010, 0, got);
        compare("mul_after_abort", got, model(8'd13, 8'd11, 5'b00010));

        // Randomized operations against the reference model.
        for (int n = 0; n < 150; n++) begin
            logic [W-1:0] ra, rb;
            logic [4:0]   rop;
            ra  = W'($urandom);
            rb  = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            rop = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 4)];
            exp_v = model(ra, rb, rop);
            run_op(ra, rb, rop, 0, got);
            compare($sformatf("rnd%0d_a%0d_b%0d_op%05b", n, ra, rb, rop), got, exp_v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
